// File: rtl/lfsr_engine.sv
// Parametrised Fibonacci LFSR with parallel load, serial shift-in, counted
// autonomous runs (start/busy/done) and a seed-return period counter.
module lfsr_engine #(
  parameter int unsigned       WIDTH     = 9,
  parameter logic [WIDTH-1:0]  TAPS      = WIDTH'(9'h110),
  parameter int unsigned       CNT_W     = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             shift,
  input  logic             d_in,
  input  logic             start,
  input  logic [CNT_W-1:0] n_steps,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             lock_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             lock_err_q, lock_err_d;

  logic             fb;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] shift_val;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  // An all-zero register would lock the LFSR forever; force it back to 1.
  assign fb        = ^(q_q & TAPS);
  assign step_val  = (q_q == '0) ? WIDTH'(1) : {q_q[WIDTH-2:0], fb};
  assign shift_val = {q_q[WIDTH-2:0], d_in};

  always_comb begin
    state_d        = state_q;
    q_d            = q_q;
    seed_d         = seed_q;
    step_cnt_d     = step_cnt_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    remaining_d    = remaining_q;
    lock_err_d     = 1'b0;

    if (load) begin
      q_d            = d;
      seed_d         = d;
      step_cnt_d     = '0;
      period_d       = '0;
      period_valid_d = 1'b0;
      remaining_d    = '0;
      state_d        = ST_IDLE;
    end else if (shift) begin
      q_d            = shift_val;
      seed_d         = shift_val;
      step_cnt_d     = '0;
      period_valid_d = 1'b0;
      remaining_d    = '0;
      state_d        = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (n_steps != '0) begin
              remaining_d = n_steps;
              state_d     = ST_RUN;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_RUN: begin
          q_d         = step_val;
          lock_err_d  = (q_q == '0);
          step_cnt_d  = sat_inc(step_cnt_q);
          remaining_d = remaining_q - CNT_W'(1);
          // Only the first return to the seed is recorded.
          if (step_val == seed_q && !period_valid_q) begin
            period_d       = sat_inc(step_cnt_q);
            period_valid_d = 1'b1;
          end
          if (remaining_q == CNT_W'(1)) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      q_q            <= RESET_VAL;
      seed_q         <= RESET_VAL;
      step_cnt_q     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      remaining_q    <= '0;
      lock_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      q_q            <= q_d;
      seed_q         <= seed_d;
      step_cnt_q     <= step_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      remaining_q    <= remaining_d;
      lock_err_q     <= lock_err_d;
    end
  end

  assign q            = q_q;
  assign serial_out   = q_q[WIDTH-1];
  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign lock_err     = lock_err_q;

endmodule
